// File: rtl/aq_gemac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aq_gemac_pkg
// Description : Shared types and widths for the GEMAC TX buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package aq_gemac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int c_tx_word_w  = 32;
    localparam int c_tx_space_w = 10;
    localparam int c_timer_w    = 10;

endpackage

`default_nettype wire

// File: rtl/aq_gemac_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : aq_gemac_rr_pick
// Description : Combinational round-robin picker, searching from ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================

module aq_gemac_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk the offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aq_gemac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : aq_gemac_tx_arb
// Description : Frame-atomic round-robin arbiter for the MAC TX buffer port.
// Revision    : 1.0 - initial release
// ============================================================================

module aq_gemac_tx_arb
    import aq_gemac_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ-1:0]          req_start,
    input  logic [NUM_REQ-1:0]          req_end,
    input  logic [32*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]          req_full,
    output logic [c_tx_space_w-1:0]     gnt_space,
    output logic                        tx_we,
    output logic                        tx_start,
    output logic                        tx_end,
    output logic [c_tx_word_w-1:0]      tx_data,
    input  logic                        tx_ready,
    input  logic                        tx_full,
    input  logic [c_tx_space_w-1:0]     tx_space,
    output logic                        busy,
    output logic                        timeout_evt,
    output logic                        drop_evt,
    output logic [15:0]                 frame_cnt
);

    localparam int                    c_idx_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_timer_w-1:0]  c_timeout = c_timer_w'(GRANT_TIMEOUT);
    localparam logic [c_idx_w-1:0]    c_ptr_rst = c_idx_w'(NUM_REQ - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [c_idx_w-1:0]     r_ptr;
    logic [c_idx_w-1:0]     r_win;
    logic [c_idx_w-1:0]     w_win_nxt;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic                   w_pick_valid;
    logic [NUM_REQ-1:0]     r_gnt;
    logic [NUM_REQ-1:0]     w_gnt_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [15:0]            r_frame_cnt;
    logic                   w_active;
    logic                   w_req;
    logic                   w_we;
    logic                   w_start;
    logic                   w_end;
    logic                   w_fwd;
    logic                   w_drop;
    logic                   w_tmo;
    logic                   w_frame_done;
    logic [c_tx_word_w-1:0] w_req_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_data[gi] = req_data[gi*32 +: 32];
    end

    aq_gemac_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_active = (r_state == ST_GRANT) || (r_state == ST_XFER);
    assign w_req    = req[r_win];
    assign w_we     = req_we[r_win];
    assign w_start  = req_start[r_win];
    assign w_end    = req_end[r_win];

    // START always takes priority over timeout expiry and a dropped request.
    always_comb begin
        w_state_nxt  = r_state;
        w_win_nxt    = r_win;
        w_fwd        = 1'b0;
        w_drop       = 1'b0;
        w_tmo        = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_ready && w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_win_nxt   = w_pick_idx;
                end
            end
            ST_GRANT: begin
                if (w_we && w_start) begin
                    w_fwd        = 1'b1;
                    w_frame_done = w_end;
                    w_state_nxt  = w_end ? ST_RELEASE : ST_XFER;
                end else begin
                    w_drop = w_we;
                    if (r_timer == c_timeout) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ST_RELEASE;
                    end else if (!w_req) begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
            end
            ST_XFER: begin
                if (w_we) begin
                    if (w_start) begin
                        w_drop = 1'b1;
                    end else begin
                        w_fwd = 1'b1;
                        if (w_end) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = ST_RELEASE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (((w_state_nxt == ST_GRANT) || (w_state_nxt == ST_XFER)) &&
                (w_win_nxt == c_idx_w'(i))) begin
                w_gnt_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= c_ptr_rst;
            r_win       <= '0;
            r_gnt       <= '0;
            r_timer     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            if (r_state == ST_RELEASE) begin
                r_ptr <= r_win;
            end
            if (r_state != ST_GRANT) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + c_timer_w'(1);
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign gnt         = r_gnt;
    assign req_full    = ~r_gnt | {NUM_REQ{tx_full}};
    assign gnt_space   = (|r_gnt) ? tx_space : '0;
    assign tx_we       = w_fwd;
    assign tx_start    = w_fwd & w_start;
    assign tx_end      = w_fwd & w_end;
    assign tx_data     = w_active ? w_req_data[r_win] : '0;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_evt = w_tmo;
    assign drop_evt    = w_drop;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_aq_gemac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_aq_gemac_tx_arb
// Description : Self-checking bench for aq_gemac_tx_arb with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_aq_gemac_tx_arb;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req, gnt, req_we, req_start, req_end, req_full;
    logic [32*N-1:0] req_data;
    logic [9:0]      gnt_space, tx_space;
    logic            tx_we, tx_start, tx_end, tx_ready, tx_full;
    logic [31:0]     tx_data;
    logic            busy, timeout_evt, drop_evt;
    logic [15:0]     frame_cnt;

    aq_gemac_tx_arb #(.NUM_REQ(N), .GRANT_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .req_we(req_we), .req_start(req_start), .req_end(req_end),
        .req_data(req_data), .req_full(req_full), .gnt_space(gnt_space),
        .tx_we(tx_we), .tx_start(tx_start), .tx_end(tx_end), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_full(tx_full), .tx_space(tx_space),
        .busy(busy), .timeout_evt(timeout_evt), .drop_evt(drop_evt),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the port, whether its frame has begun,
    // how long it has waited, and whether we are in the dead release cycle.
    int          m_owner, m_last, m_wait;
    bit          m_started, m_rel;
    logic [15:0] m_frames;

    int          n_checks, n_pass, cyc, g_drops;
    logic [N-1:0] s_gnt;
    logic        s_tmo, s_drop, s_tx_end;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_wait = 0;
        m_started = 0; m_rel = 0; m_frames = '0;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_strobes();
        req_we = '0; req_start = '0; req_end = '0;
    endtask

    task automatic put(input int i, input logic w, input logic s, input logic e);
        req_we[i] = w; req_start[i] = s; req_end[i] = e;
        req_data[32*i +: 32] = $urandom;
    endtask

    // Inputs are already applied; check at mid-cycle, then advance the model.
    task automatic cycle();
        int o;
        bit found;
        logic w, s, e, fwd, drop, tmo, done, rel;
        logic [N-1:0] eg, ef;
        logic [31:0] d;
        #4;
        cyc++;
        if (!rst_n) model_reset();
        o = m_owner;
        w = 0; s = 0; e = 0; fwd = 0; drop = 0; tmo = 0; done = 0; rel = 0;
        eg = '0; ef = '1; d = '0;
        if (o >= 0) begin
            w = req_we[o]; s = req_start[o]; e = req_end[o];
            d = req_data[32*o +: 32];
            eg[o] = 1'b1; ef[o] = tx_full;
            if (!m_started) begin
                if (w && s) begin fwd = 1; done = e; rel = e; end
                else begin
                    drop = w;
                    if (m_wait == TO) begin tmo = 1; rel = 1; end
                    else if (!req[o]) rel = 1;
                end
            end else if (w) begin
                if (s) drop = 1;
                else begin fwd = 1; done = e; rel = e; end
            end
        end
        chk("gnt", gnt, eg);
        chk("tx_we", tx_we, fwd);
        chk("tx_start", tx_start, fwd & s);
        chk("tx_end", tx_end, fwd & e);
        if (fwd) chk("tx_data", tx_data, d);
        if (!rst_n) chk("rst_tx_data", tx_data, 32'd0);
        chk("req_full", req_full, ef);
        chk("gnt_space", gnt_space, (o >= 0) ? tx_space : 10'd0);
        chk("busy", busy, (o >= 0) || m_rel);
        chk("timeout_evt", timeout_evt, tmo);
        chk("drop_evt", drop_evt, drop);
        chk("frame_cnt", frame_cnt, m_frames);
        s_gnt = gnt; s_tmo = timeout_evt; s_drop = drop_evt; s_tx_end = tx_end;
        if (drop_evt) g_drops++;
        if (rst_n) begin
            if (done) m_frames++;
            if (o >= 0) begin
                if (rel) begin m_owner = -1; m_rel = 1; m_last = o; end
                else begin m_started = m_started | fwd; m_wait++; end
            end else if (m_rel) begin
                m_rel = 0;
            end else if (tx_ready && req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (req[j] && !found) begin
                        found = 1; m_owner = j; m_wait = 0; m_started = 0;
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic word(input int i, input logic w, input logic s, input logic e);
        clear_strobes();
        put(i, w, s, e);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_ord[5];
        int order[$];
        int gaps[$];
        int last_end, a_owner, wc, budget, d0, t_gnt, t_tmo;
        logic [N-1:0] pg;
        bit any;

        exp_ord = '{0, 1, 2, 3, 0};
        n_checks = 0; n_pass = 0; cyc = 0; g_drops = 0;
        model_reset();
        rst_n = 1'b0; req = '0; clear_strobes(); req_data = '0;
        tx_ready = 1'b1; tx_full = 1'b0; tx_space = 10'd300;
        @(posedge clk); #1;

        // Reset values with activity on the request lines
        repeat (3) begin req = N'($urandom); cycle(); end
        rst_n = 1'b1; req = '0; cycle();

        // Fairness: all requesting, each sends a 3-word frame
        req = '1; a_owner = -1; wc = 0; last_end = -100; pg = '0; budget = 0;
        while (budget < 80 && !(order.size() == 5 && m_owner < 0 && !m_rel)) begin
            clear_strobes();
            if (m_owner != a_owner) begin a_owner = m_owner; wc = 0; end
            if (m_owner >= 0) begin put(m_owner, 1'b1, wc == 0, wc == 2); wc++; end
            req = (order.size() < 5) ? '1 : '0;
            cycle();
            if (s_tx_end) last_end = cyc;
            if (s_gnt != '0 && pg == '0) begin
                order.push_back(oh2i(s_gnt));
                if (last_end >= 0) gaps.push_back(cyc - last_end);
            end
            pg = s_gnt;
            budget++;
        end
        chk("fair_budget", budget < 80, 1'b1);
        chk("fair_count", order.size(), 5);
        for (int i = 0; i < 5; i++) chk("fair_order", (order.size() > i) ? order[i] : -1, exp_ord[i]);
        chk("fair_gap_count", gaps.size(), 4);
        foreach (gaps[i]) chk("fair_gap", gaps[i], 3);

        // Single-word frame
        clear_strobes(); req = 4'b0001; cycle();
        word(0, 1'b1, 1'b1, 1'b1);
        clear_strobes(); req = '0; cycle();
        chk("single_gnt_fall", s_gnt, 4'b0000);
        chk("single_frame_cnt", frame_cnt, 16'd6);
        repeat (2) cycle();

        // Atomicity: requester 2 keeps the port after dropping REQ
        req = 4'b0100; cycle();
        d0 = g_drops;
        word(2, 1'b1, 1'b1, 1'b0);
        req = 4'b0001;
        clear_strobes(); put(2, 1'b1, 1'b0, 1'b0); put(0, 1'b1, 1'b1, 1'b0); cycle();
        clear_strobes(); put(2, 1'b1, 1'b0, 1'b0); put(0, 1'b1, 1'b0, 1'b0); cycle();
        clear_strobes(); put(2, 1'b1, 1'b0, 1'b1); put(0, 1'b1, 1'b0, 1'b1); cycle();
        chk("atom_drop", g_drops - d0, 0);
        clear_strobes(); req = '0; cycle(); cycle();
        chk("atom_frame_cnt", frame_cnt, 16'd7);

        // Timeout: requester 1 never writes
        req = 4'b0110; cycle();
        t_gnt = -1; t_tmo = -1; budget = 0;
        while (budget < 150 && !(t_tmo >= 0 && s_gnt != '0 && s_gnt != 4'b0010)) begin
            cycle();
            if (s_gnt == 4'b0010 && t_gnt < 0) t_gnt = cyc;
            if (s_tmo && t_tmo < 0) t_tmo = cyc;
            budget++;
        end
        chk("tmo_latency", t_tmo - t_gnt, 64);
        chk("tmo_next_gnt", s_gnt, 4'b0100);
        req = '0; cycle(); cycle();

        // Protocol drops: WE without START, then a repeated START
        req = 4'b1000; cycle();
        d0 = g_drops;
        word(3, 1'b1, 1'b0, 1'b0);
        word(3, 1'b1, 1'b1, 1'b0);
        word(3, 1'b1, 1'b1, 1'b0);
        word(3, 1'b1, 1'b0, 1'b0);
        word(3, 1'b1, 1'b0, 1'b1);
        clear_strobes(); req = '0; cycle(); cycle();
        chk("proto_drops", g_drops - d0, 2);
        chk("proto_frame_cnt", frame_cnt, 16'd8);

        // TX_READY gating
        tx_ready = 1'b0; req = '1; any = 0;
        repeat (10) begin cycle(); any = any | (s_gnt != '0); end
        chk("gate_no_grant", any, 1'b0);
        tx_ready = 1'b1;

        // Randomized traffic against the model
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
                req_we[i]    = ($urandom_range(0, 9) < 4);
                req_start[i] = ($urandom_range(0, 9) < 3);
                req_end[i]   = ($urandom_range(0, 9) < 3);
                req_data[32*i +: 32] = $urandom;
            end
            tx_ready = ($urandom_range(0, 9) != 0);
            tx_full  = ($urandom_range(0, 3) == 0);
            tx_space = 10'($urandom);
            cycle();
        end

        // Drain any open frame
        tx_ready = 1'b1; tx_full = 1'b0; req = '0; budget = 0;
        while (budget < 20 && (m_owner >= 0 || m_rel)) begin
            clear_strobes();
            if (m_owner >= 0) put(m_owner, 1'b1, !m_started, 1'b1);
            cycle();
            budget++;
        end
        clear_strobes(); cycle();

        // Reset in the middle of a frame
        req = 4'b0001; cycle();
        word(0, 1'b1, 1'b1, 1'b1);
        clear_strobes(); req = '0; cycle(); cycle();
        req = 4'b0100; cycle();
        word(2, 1'b1, 1'b1, 1'b0);
        word(2, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0; clear_strobes(); req = '1; cycle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        rst_n = 1'b1; cycle(); cycle();
        chk("post_rst_gnt", s_gnt, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
